host_exit_monitor: RTL and testbench
====================================

HOST_EXIT_MONITOR -- requirements
Module: host_exit_monitor

Interface
REQ-001 SHALL have parameter NUM_CHANNELS, default 2: number of tohost channels watched.
REQ-002 SHALL have parameter WIDTH, default 8: bits per tohost channel.
REQ-003 SHALL have parameter MATCH_MODE, default 0: 0 = exact match against EXIT_CODE; 1 = any value with bit 0 set, code = value >> 1.
REQ-004 SHALL have parameter EXIT_CODE, default 8'h01: exit value used when MATCH_MODE=0.
REQ-005 SHALL have parameter STABLE_CYCLES, default 1, legal range 1-255: consecutive identical qualifying samples required to declare exit.
REQ-006 SHALL have parameter TIMEOUT_CYCLES, default 2000: RUN cycles before timeout; 0 disables timeout.
REQ-007 SHALL have parameter CYCLE_WIDTH, default 32: width of the cycle counter.
REQ-008 SHALL have port clock, input, 1: sole clock; all state updates on the rising edge.
REQ-009 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-010 SHALL have port io_start, input, 1: pulse; moves IDLE to RUN.
REQ-011 SHALL have port io_clear, input, 1: pulse; returns any state to IDLE.
REQ-012 SHALL have port io_tohost, input, NUM_CHANNELS*WIDTH: channel i occupies bits [i*WIDTH +: WIDTH].
REQ-013 SHALL have port io_done, output, 1: high in EXITED or TIMEDOUT.
REQ-014 SHALL have port io_exit, output, 1: high in EXITED.
REQ-015 SHALL have port io_timeout, output, 1: high in TIMEDOUT.
REQ-016 SHALL have port io_exit_channel, output, max(1,$clog2(NUM_CHANNELS)): index of the exiting channel.
REQ-017 SHALL have port io_exit_code, output, WIDTH: latched code (raw value in mode 0; value >> 1, zero-extended, in mode 1).
REQ-018 SHALL have port io_cycles, output, CYCLE_WIDTH: cycles spent in RUN.

Function
REQ-019 SHALL implement states IDLE, RUN, EXITED, TIMEDOUT, with all outputs driven from registers.
REQ-020 SHALL transition IDLE->RUN on io_start, and SHALL ignore io_start in all other states.
REQ-021 SHALL define a per-channel stability count: 0 when the sample does not qualify; 1 when it qualifies and differs from the previous sample or the previous sample did not qualify; otherwise previous+1, saturating at STABLE_CYCLES.
REQ-022 SHALL update stability counts only in RUN, and SHALL zero them in all other states.
REQ-023 SHALL transition RUN->EXITED on the edge at which any channel's count reaches STABLE_CYCLES, latching io_exit_channel and io_exit_code on that same edge; io_exit is visible the following cycle.
REQ-024 SHALL give priority to the lowest channel index when several channels qualify on the same edge.
REQ-025 SHALL increment io_cycles once per RUN cycle, saturate at all-ones, hold it in EXITED/TIMEDOUT, and zero it on the transition into RUN.
REQ-026 SHALL transition RUN->TIMEDOUT when TIMEOUT_CYCLES != 0 and the RUN cycle count reaches TIMEOUT_CYCLES.
REQ-027 SHALL give exit priority over timeout when both occur on the same edge.
REQ-028 SHALL treat EXITED and TIMEDOUT as sticky, ignoring io_tohost, until io_clear or reset.
REQ-029 SHALL give io_clear priority over io_start and over exit/timeout detection on the same edge, and SHALL zero io_exit_channel, io_exit_code and io_cycles on clear.

Reset
REQ-030 SHALL, on reset, enter IDLE and drive io_done=0, io_exit=0, io_timeout=0, io_exit_channel=0, io_exit_code=0, io_cycles=0, with all stability counts zero.
REQ-031 SHALL give reset priority over all other inputs, and SHALL abort mid-RUN with no exit reported.

Verification
REQ-032 SHALL be verified as follows: defaults, start, ch0 = 8'h01 from RUN cycle 5 -> io_exit=1, channel=0, code=8'h01, io_cycles=6.
REQ-033 SHALL be verified as follows: STABLE_CYCLES=3, ch1 toggles 01/00/01/01/01 -> exit only after third consecutive 01; channel=1.
REQ-034 SHALL be verified as follows: MATCH_MODE=1, ch0 = 8'h00, ch1 = 8'h07 simultaneously with ch0 = 8'h05 -> channel=0, code=8'h02.
REQ-035 SHALL be verified as follows: TIMEOUT_CYCLES=20, no qualifying tohost -> io_timeout=1 after 20 RUN cycles, io_cycles=20, held until io_clear.
REQ-036 SHALL be verified as follows: exit qualifies on the timeout edge -> io_exit=1, io_timeout=0.
REQ-037 SHALL be verified as follows: reset asserted mid-RUN, then io_clear with io_start on the same edge after EXITED -> reset gives all outputs 0, state IDLE; io_clear wins and stays in IDLE.

Source files
------------

// File: rtl/host_exit_monitor.sv
// rtl/host_exit_monitor.sv - watches tohost channels for a stable exit value or a RUN timeout
// Sticky EXITED/TIMEDOUT result; all outputs are registered.
module host_exit_monitor #(
  parameter int unsigned NUM_CHANNELS   = 2,
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned MATCH_MODE     = 0,
  parameter int unsigned EXIT_CODE      = 32'h01,
  parameter int unsigned STABLE_CYCLES  = 1,
  parameter int unsigned TIMEOUT_CYCLES = 2000,
  parameter int unsigned CYCLE_WIDTH    = 32,
  localparam int unsigned CH_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            io_start,
  input  logic                            io_clear,
  input  logic [NUM_CHANNELS*WIDTH-1:0]   io_tohost,
  output logic                            io_done,
  output logic                            io_exit,
  output logic                            io_timeout,
  output logic [CH_W-1:0]                 io_exit_channel,
  output logic [WIDTH-1:0]                io_exit_code,
  output logic [CYCLE_WIDTH-1:0]          io_cycles
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_EXITED, S_TIMEDOUT} state_t;

  localparam logic [7:0] STAB8 = 8'(STABLE_CYCLES);

  state_t                                r_state;
  logic                                  r_done;
  logic                                  r_exit;
  logic                                  r_timeout;
  logic [CH_W-1:0]                       r_exit_channel;
  logic [WIDTH-1:0]                      r_exit_code;
  logic [CYCLE_WIDTH-1:0]                r_cycles;
  logic [NUM_CHANNELS-1:0][WIDTH-1:0]    r_prev;
  logic [NUM_CHANNELS-1:0][7:0]          r_cnt;

  logic [NUM_CHANNELS-1:0][WIDTH-1:0]    w_chan;
  logic [NUM_CHANNELS-1:0][WIDTH-1:0]    w_code;
  logic [NUM_CHANNELS-1:0][7:0]          w_cnt_next;
  logic [NUM_CHANNELS-1:0]               w_qual;
  logic [NUM_CHANNELS-1:0]               w_hit;
  logic                                  w_any_hit;
  logic [CH_W-1:0]                       w_hit_ch;
  logic [WIDTH-1:0]                      w_hit_code;
  logic [CYCLE_WIDTH-1:0]                w_cycles_inc;
  logic                                  w_timeout_hit;

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
    assign w_chan[g] = io_tohost[g*WIDTH +: WIDTH];
    if (MATCH_MODE == 1) begin : g_bit0
      assign w_qual[g] = w_chan[g][0];
      assign w_code[g] = {1'b0, w_chan[g][WIDTH-1:1]};
    end else begin : g_exact
      assign w_qual[g] = (w_chan[g] == EXIT_CODE[WIDTH-1:0]);
      assign w_code[g] = w_chan[g];
    end
    // A zero count means the previous sample did not qualify, so the run restarts at 1.
    assign w_cnt_next[g] = !w_qual[g] ? 8'd0 :
                           ((r_cnt[g] == 8'd0) || (w_chan[g] != r_prev[g])) ? 8'd1 :
                           (r_cnt[g] >= STAB8) ? STAB8 : r_cnt[g] + 8'd1;
    assign w_hit[g] = (w_cnt_next[g] == STAB8);
  end

  always_comb begin
    w_hit_ch   = '0;
    w_hit_code = '0;
    for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
      if (w_hit[i]) begin
        w_hit_ch   = CH_W'(i);
        w_hit_code = w_code[i];
      end
    end
  end

  assign w_any_hit     = |w_hit;
  assign w_cycles_inc  = (&r_cycles) ? r_cycles : r_cycles + CYCLE_WIDTH'(1);
  assign w_timeout_hit = (TIMEOUT_CYCLES != 0) &&
                         (w_cycles_inc == CYCLE_WIDTH'(TIMEOUT_CYCLES));

  always_ff @(posedge clock) begin
    if (reset || io_clear) begin
      r_state        <= S_IDLE;
      r_done         <= 1'b0;
      r_exit         <= 1'b0;
      r_timeout      <= 1'b0;
      r_exit_channel <= '0;
      r_exit_code    <= '0;
      r_cycles       <= '0;
      r_prev         <= '0;
      r_cnt          <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (io_start) begin
            r_state  <= S_RUN;
            r_cycles <= '0;
          end
        end
        S_RUN: begin
          r_cycles <= w_cycles_inc;
          r_prev   <= w_chan;
          r_cnt    <= w_cnt_next;
          if (w_any_hit) begin
            r_state        <= S_EXITED;
            r_done         <= 1'b1;
            r_exit         <= 1'b1;
            r_exit_channel <= w_hit_ch;
            r_exit_code    <= w_hit_code;
            r_cnt          <= '0;
          end else if (w_timeout_hit) begin
            r_state   <= S_TIMEDOUT;
            r_done    <= 1'b1;
            r_timeout <= 1'b1;
            r_cnt     <= '0;
          end
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  assign io_done         = r_done;
  assign io_exit         = r_exit;
  assign io_timeout      = r_timeout;
  assign io_exit_channel = r_exit_channel;
  assign io_exit_code    = r_exit_code;
  assign io_cycles       = r_cycles;

endmodule

// File: tb/tb_host_exit_monitor.sv
// tb/tb_host_exit_monitor.sv - directed vector bench for host_exit_monitor
// Three instances (defaults, stable=3/timeout=20, match mode 1) share the same stimulus.
module tb_host_exit_monitor;

  logic        clock = 1'b0;
  logic        reset, clear, start;
  logic [15:0] tohost;

  always #5 clock = ~clock;

  logic a_done, a_exit, a_to, b_done, b_exit, b_to, c_done, c_exit, c_to;
  logic [0:0]  a_ch, b_ch, c_ch;
  logic [7:0]  a_code, b_code, c_code;
  logic [31:0] a_cyc, b_cyc, c_cyc;

  host_exit_monitor u_a (
    .clock(clock), .reset(reset), .io_start(start), .io_clear(clear), .io_tohost(tohost),
    .io_done(a_done), .io_exit(a_exit), .io_timeout(a_to), .io_exit_channel(a_ch),
    .io_exit_code(a_code), .io_cycles(a_cyc));

  host_exit_monitor #(.STABLE_CYCLES(3), .TIMEOUT_CYCLES(20)) u_b (
    .clock(clock), .reset(reset), .io_start(start), .io_clear(clear), .io_tohost(tohost),
    .io_done(b_done), .io_exit(b_exit), .io_timeout(b_to), .io_exit_channel(b_ch),
    .io_exit_code(b_code), .io_cycles(b_cyc));

  host_exit_monitor #(.MATCH_MODE(1)) u_c (
    .clock(clock), .reset(reset), .io_start(start), .io_clear(clear), .io_tohost(tohost),
    .io_done(c_done), .io_exit(c_exit), .io_timeout(c_to), .io_exit_channel(c_ch),
    .io_exit_code(c_code), .io_cycles(c_cyc));

  wire [43:0] a_out = {a_done, a_exit, a_to, a_ch, a_code, a_cyc};
  wire [43:0] b_out = {b_done, b_exit, b_to, b_ch, b_code, b_cyc};
  wire [43:0] c_out = {c_done, c_exit, c_to, c_ch, c_code, c_cyc};

  typedef struct packed {
    logic        rst, clr, st;
    logic [15:0] th;
    logic [43:0] exp;
  } vec_t;

  vec_t tbl[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic logic [43:0] pk(input logic d, e, t, input logic ch,
                                     input logic [7:0] code, input logic [31:0] cyc);
    return {d, e, t, ch, code, cyc};
  endfunction

  task automatic add(input logic r, c, s, input logic [15:0] th, input logic [43:0] exp);
    vec_t v;
    v.rst = r; v.clr = c; v.st = s; v.th = th; v.exp = exp;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic r, c, s, input logic [15:0] th);
    reset = r; clear = c; start = s; tohost = th;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string nm, input logic [43:0] act, input logic [43:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got done/exit/to/ch/code/cyc=%h, expected %h", nm, act, exp);
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b0, 16'h0000);

    add(1, 0, 0, 16'h0000, pk(0, 0, 0, 0, 8'h00, 0));
    add(0, 0, 0, 16'h0001, pk(0, 0, 0, 0, 8'h00, 0));
    add(0, 0, 1, 16'h0000, pk(0, 0, 0, 0, 8'h00, 0));
    for (int k = 1; k <= 5; k++) add(0, 0, 0, 16'h0000, pk(0, 0, 0, 0, 8'h00, k));
    add(0, 0, 0, 16'h0001, pk(1, 1, 0, 0, 8'h01, 6));
    add(0, 0, 1, 16'h0000, pk(1, 1, 0, 0, 8'h01, 6));
    add(0, 1, 1, 16'h0001, pk(0, 0, 0, 0, 8'h00, 0));
    add(0, 0, 0, 16'h0001, pk(0, 0, 0, 0, 8'h00, 0));
    add(0, 0, 1, 16'h0000, pk(0, 0, 0, 0, 8'h00, 0));
    add(0, 0, 0, 16'h0203, pk(0, 0, 0, 0, 8'h00, 1));
    add(0, 0, 0, 16'h0101, pk(1, 1, 0, 0, 8'h01, 2));
    add(0, 1, 0, 16'h0000, pk(0, 0, 0, 0, 8'h00, 0));
    add(0, 0, 1, 16'h0000, pk(0, 0, 0, 0, 8'h00, 0));
    add(0, 0, 0, 16'h0100, pk(1, 1, 0, 1, 8'h01, 1));
    add(0, 1, 0, 16'h0000, pk(0, 0, 0, 0, 8'h00, 0));
    add(0, 0, 1, 16'h0000, pk(0, 0, 0, 0, 8'h00, 0));
    add(0, 0, 0, 16'h0000, pk(0, 0, 0, 0, 8'h00, 1));
    add(1, 0, 0, 16'h0001, pk(0, 0, 0, 0, 8'h00, 0));
    add(0, 0, 0, 16'h0001, pk(0, 0, 0, 0, 8'h00, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].clr, tbl[i].st, tbl[i].th);
      step();
      chk($sformatf("a_row%0d", i), a_out, tbl[i].exp);
    end

    // Stable count of 3 on ch1 with a gap in the middle.
    drive(1, 0, 0, 16'h0000); step();
    chk("b_reset", b_out, pk(0, 0, 0, 0, 8'h00, 0));
    drive(0, 0, 1, 16'h0000); step();
    drive(0, 0, 0, 16'h0100); step();
    drive(0, 0, 0, 16'h0000); step();
    drive(0, 0, 0, 16'h0100); step();
    drive(0, 0, 0, 16'h0100); step();
    chk("b_stable_pre", b_out, pk(0, 0, 0, 0, 8'h00, 4));
    drive(0, 0, 0, 16'h0100); step();
    chk("b_stable_exit", b_out, pk(1, 1, 0, 1, 8'h01, 5));

    drive(0, 1, 0, 16'h0000); step();
    drive(0, 0, 1, 16'h0000); step();
    drive(0, 0, 0, 16'h0000);
    for (int k = 0; k < 19; k++) step();
    chk("b_timeout_pre", b_out, pk(0, 0, 0, 0, 8'h00, 19));
    step();
    chk("b_timeout", b_out, pk(1, 0, 1, 0, 8'h00, 20));
    drive(0, 0, 1, 16'h0001);
    for (int k = 0; k < 3; k++) step();
    chk("b_timeout_sticky", b_out, pk(1, 0, 1, 0, 8'h00, 20));
    drive(0, 1, 0, 16'h0000); step();
    chk("b_timeout_clear", b_out, pk(0, 0, 0, 0, 8'h00, 0));

    drive(0, 0, 1, 16'h0000); step();
    drive(0, 0, 0, 16'h0000);
    for (int k = 0; k < 17; k++) step();
    drive(0, 0, 0, 16'h0001); step(); step();
    chk("b_race_pre", b_out, pk(0, 0, 0, 0, 8'h00, 19));
    step();
    chk("b_exit_beats_timeout", b_out, pk(1, 1, 0, 0, 8'h01, 20));

    // Match mode 1: bit 0 qualifies, code is value >> 1, lowest channel wins.
    drive(1, 0, 0, 16'h0000); step();
    drive(0, 0, 1, 16'h0000); step();
    drive(0, 0, 0, 16'h0000); step();
    chk("c_no_qual", c_out, pk(0, 0, 0, 0, 8'h00, 1));
    drive(0, 0, 0, 16'h0705); step();
    chk("c_priority", c_out, pk(1, 1, 0, 0, 8'h02, 2));
    drive(0, 1, 0, 16'h0000); step();
    drive(0, 0, 1, 16'h0000); step();
    drive(0, 0, 0, 16'hFF00); step();
    chk("c_ch1_max", c_out, pk(1, 1, 0, 1, 8'h7F, 1));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
